// File: rtl/rsv_wb_arbiter_if.sv
// rsv_wb_arbiter_if: ALU/LSU writeback requests and register-file write port
interface rsv_wb_arbiter_if #(
   parameter int XLEN = 32
);
   logic            alu_valid_i;
   logic [4:0]      alu_rd_i;
   logic [XLEN-1:0] alu_data_i;
   logic            alu_ready_o;
   logic            lsu_valid_i;
   logic [4:0]      lsu_rd_i;
   logic [XLEN-1:0] lsu_data_i;
   logic            lsu_ready_o;
   logic            rf_wr_en_o;
   logic [5:0]      rf_waddr_o;
   logic [XLEN-1:0] rf_data_o;
   logic            init_done_o;
   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
      output alu_ready_o, lsu_ready_o, rf_wr_en_o, rf_waddr_o, rf_data_o, init_done_o
   );
   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
      input  alu_ready_o, lsu_ready_o, rf_wr_en_o, rf_waddr_o, rf_data_o, init_done_o
   );
endinterface

// File: rtl/rsv_wb_arbiter.sv
// rsv_wb_arbiter: round-robin ALU/LSU writeback arbiter with register-file zero-init sweep
module rsv_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   rsv_wb_arbiter_if.slave bus
);
   typedef enum logic {INIT, RUN} state_t;
   state_t          state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            prio_q, prio_d;
   logic            wr_en_q, wr_en_d;
   logic            done_q, done_d;
   logic [5:0]      waddr_q, waddr_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            alu_gnt, lsu_gnt;
   always_comb begin
      alu_gnt = state_q == RUN && bus.alu_valid_i && (!bus.lsu_valid_i || !prio_q);
      lsu_gnt = state_q == RUN && bus.lsu_valid_i && (!bus.alu_valid_i || prio_q);
      state_d = state_q;
      cnt_d   = cnt_q;
      prio_d  = prio_q;
      wr_en_d = 1'b0;
      done_d  = done_q;
      waddr_d = waddr_q;
      data_d  = data_q;
      if (state_q == INIT) begin
         wr_en_d = 1'b1;
         waddr_d = {1'b0, cnt_q};
         data_d  = '0;
         cnt_d   = cnt_q + 5'd1;
         state_d = cnt_q == 5'(NREG - 1) ? RUN : INIT;
         done_d  = cnt_q == 5'(NREG - 1);
      end else if (alu_gnt || lsu_gnt) begin
         waddr_d = {1'b0, alu_gnt ? bus.alu_rd_i : bus.lsu_rd_i};
         data_d  = alu_gnt ? bus.alu_data_i : bus.lsu_data_i;
         // x0 is accepted but never written once the sweep is over
         wr_en_d = |waddr_d;
         prio_d  = alu_gnt;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
         prio_q  <= 1'b0;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         waddr_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prio_q  <= prio_d;
         wr_en_q <= wr_en_d;
         done_q  <= done_d;
         waddr_q <= waddr_d;
         data_q  <= data_d;
      end
   end
   assign bus.alu_ready_o = alu_gnt;
   assign bus.lsu_ready_o = lsu_gnt;
   assign bus.rf_wr_en_o  = wr_en_q;
   assign bus.rf_waddr_o  = waddr_q;
   assign bus.rf_data_o   = data_q;
   assign bus.init_done_o = done_q;
endmodule

// File: doc/rsv_wb_arbiter.md
# rsv_wb_arbiter

Writeback arbiter and register-file initialiser for the RV32I core. It shares the register file's single write port between the ALU writeback path and the load/store unit (LSU) writeback path using round-robin priority with a valid/ready handshake. After every reset it first sequences zero-writes through all 32 architectural registers, then switches to normal arbitration. It sits between the execute/memory stages and the register-file write port (waddr/data/wr_en).

## Interface
- `XLEN`, 32: data width.
- `NREG`, 32: number of registers cleared at init.
- `clk` input 1: clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `alu_valid_i` input 1: ALU writeback request.
- `alu_rd_i` input 5: ALU destination register.
- `alu_data_i` input XLEN: ALU result.
- `alu_ready_o` output 1: ALU request accepted this cycle when high with valid.
- `lsu_valid_i` input 1: LSU writeback request.
- `lsu_rd_i` input 5: LSU destination register.
- `lsu_data_i` input XLEN: load result.
- `lsu_ready_o` output 1: LSU request accepted this cycle when high with valid.
- `rf_wr_en_o` output 1: register-file write enable (registered).
- `rf_waddr_o` output 6: register-file write address (registered); bit 5 is always 0.
- `rf_data_o` output XLEN: register-file write data (registered).
- `init_done_o` output 1: high once the init sweep has completed.

## Operation
- Two-state FSM: INIT and RUN.
- **INIT**
  - 5-bit counter `cnt` starts at 0.
  - Each cycle drives a write of zero to `cnt`, then increments `cnt`.
  - When `cnt`==NREG-1 is issued, the FSM moves to RUN.
  - Both ready outputs are 0 throughout INIT; requester valids are ignored.
- **RUN**
  - Handshake occurs when valid && ready on the same edge.
  - Only ALU valid: `alu_ready_o`=1.
  - Only LSU valid: `lsu_ready_o`=1.
  - Both valid: the grant goes to the requester selected by pointer `prio` (0=ALU, 1=LSU); the other requester's ready is 0.
  - After any grant, contested or not, `prio` points to the non-granted requester. Example: ALU granted → `prio`=1.
  - The granted rd/data are registered onto `rf_waddr_o`/`rf_data_o`; `rf_wr_en_o`=1 on the next cycle.
  - rd==0: the request is accepted (ready asserted, `prio` updated) but `rf_wr_en_o` stays 0. x0 is never written after init.
  - No request: `rf_wr_en_o`=0; addr/data hold their last value.
- A requester must hold valid, rd and data stable until accepted. The arbiter never drops or duplicates an accepted request.
- Ready outputs are combinational from FSM state, both valids and `prio`; they never depend on rd or data.

## Timing
- **Reset (asynchronous, any cycle, including mid-INIT or mid-RUN)**
  - `rf_wr_en_o`=0, `rf_waddr_o`=0, `rf_data_o`=0, `init_done_o`=0, both readys 0.
  - FSM=INIT, `cnt`=0, `prio`=0.
  - Any in-flight write is abandoned and the init sweep restarts.
- **Init sweep**
  - At rising edges 1..32 after `reset_n` deassertion, `rf_wr_en_o`=1, `rf_waddr_o`=0..31, `rf_data_o`=0.
  - `init_done_o` rises at edge 32 and stays high until reset.
  - Readys may be high from the cycle following edge 32.
- **RUN latency**: handshake at edge N → write visible on `rf_*_o` after edge N+1, i.e. one cycle.
- **Throughput**: one write per cycle, sustained.
- **Starvation**: with both requesters valid continuously, grants strictly alternate.

## Test plan
- **Reset/init**: release `reset_n`, no requests → 32 consecutive writes (addr 0..31, data 0), then `init_done_o`=1 and `rf_wr_en_o`=0.
- **ALU only**: ALU valid, rd=5, data=0x1234_5678 → `alu_ready_o`=1 the same cycle; next cycle `rf_wr_en_o`=1, `rf_waddr_o`=5, `rf_data_o`=0x1234_5678.
- **Contention**: both valid continuously (ALU rd=1 data=0xA, LSU rd=2 data=0xB, new values after each accept) → write order ALU, LSU, ALU, LSU; no cycle grants both.
- **x0 drop**: LSU valid, rd=0, data=0xFFFF_FFFF → `lsu_ready_o`=1, `rf_wr_en_o` stays 0, `prio` flips to ALU.
- **Requests during init**: both valid from reset release → both readys 0 for 32 cycles, no request write during the sweep; the first grant goes to the ALU after `init_done_o`.
- **Mid-operation reset**: assert `reset_n`=0 during contended RUN traffic → all outputs 0 immediately (asynchronously); after release the full 32-write sweep repeats before any grant.
